game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//   Top-level 2048 game sequencer. Owns the 64-bit board register and drives the 3-bit game state.
//   The AI search block observes both and returns a move on ai_dir.
//   Each turn takes a move from the push-buttons (manual) or from ai_dir (auto), then slides/merges, spawns a tile and checks for win/loss.
//   Board: nibble i = bits [4i+3:4i] = log2 of the tile value (0 = empty). Row r = idx 4r..4r+3; col c = idx mod 4.
//   LEFT slides toward c=0; UP slides toward r=0.
// PARAMETERS
//   INIT_BOARD      64'h0000_0000_0000_0011  board loaded on reset/restart
//   WIN_EXP         4'd11                    exponent that wins (2048)
//   SEARCH_TIMEOUT  32'd20_000_000           max cycles in SEARCH before fallback move
//   LFSR_SEED       16'hACE1                 spawn LFSR seed (must be nonzero)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   asynchronous, active-low reset
//   btn_up/btn_down/btn_left/btn_right  in 1  debounced level inputs; rising edge = request
//   btn_restart  in   1   rising edge restarts the game from any state
//   auto_mode    in   1   1 = moves come from ai_dir, 0 = from buttons; sampled in INPUT
//   ai_dir       in   3   AI move (1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 0 = not ready)
//   state        out  3   0 INPUT, 1 MERGE, 2 GEN, 3 CHECK, 4 END, 5 SEARCH
//   board        out  64  current board
//   won          out  1   set on entry to END when a WIN_EXP tile exists
//   game_over    out  1   high while in END
//   move_count   out  16  accepted (board-changing) moves; saturates at 16'hFFFF
//   score        out  24  sum of merged tile values; saturates (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=INPUT, board=INIT_BOARD, won=0, game_over=0, move_count=0, score=0, LFSR=LFSR_SEED, button edge regs=0.
//   INPUT: one cycle minimum, which restarts the AI countdown.
//     auto_mode=1 -> SEARCH next cycle.
//     auto_mode=0 -> wait for a button rising edge; capture dir -> MERGE. Priority when simultaneous: UP>DOWN>LEFT>RIGHT.
//   SEARCH: first cycle with ai_dir!=0 -> capture dir -> MERGE.
//     Timeout after SEARCH_TIMEOUT cycles -> first legal dir in order DOWN, LEFT, RIGHT, UP -> MERGE.
//     Edges of btn_* are ignored in SEARCH.
//   MERGE (1 cycle): per line, compact toward the move side, then merge equal adjacent pairs once, nearest the wall first.
//     Example: [1,1,1,1] -> [2,2,0,0]. A merged tile's exponent is e+1; exponent 15 does not merge.
//     moved == board -> INPUT; board, score and move_count unchanged.
//     Otherwise board<=moved, move_count+1, score += sum(2^(e+1)) over merges -> GEN.
//   GEN (1 cycle): n = empty count (>=1 guaranteed). k = lfsr[15:4] mod n; fill the k-th empty cell in ascending index.
//     Value is 2 (exp 2) if lfsr[2:0]==0, else 1. LFSR (x^16+x^14+x^13+x^11) steps every cycle in every state.
//   CHECK (1 cycle): any nibble==WIN_EXP -> END, won=1.
//     Else no empty cell and no equal horizontal/vertical neighbours -> END, won=0. Else -> INPUT.
//   END: game_over=1; board frozen; waits for btn_restart.
//   Restart edge, any state: next cycle board=INIT_BOARD, score=0, move_count=0, won=0, state=INPUT. Restart beats any move request in the same cycle.
//   Async reset mid-turn aborts immediately to reset values; no partial board update is kept.
// CONFIGURATION
//   GAME_SCORE_EN defined: score accumulates as above; 24-bit add saturates at 24'hFFFFFF.
//   GAME_SCORE_EN undefined: no score logic; score tied to 24'd0. All other behaviour identical.
// STRUCTURE
//   Shared header game_defs.vh: state codes (INPUT..SEARCH), dir codes (UP..RIGHT), nibble/row/col index macros.
//     The AI block includes the same header.
//   Sub-module tile_spawner: LFSR + empty-cell count + k-th-empty select; inputs clk, rst, board; outputs spawned board.
//   Line slide/merge/gain is a local function applied to 4 lines, with index remap per direction.
// TESTING
//   Reset with rst=0 -> state=0, board=64'h11, score=0, move_count=0, won=0.
//   Manual LEFT, row0 = {c0=1,c1=1,c2=2,c3=0}, rest empty -> after MERGE row0={2,2,0,0}; score=4; move_count=1; one new tile with exp 1 or 2; back to INPUT.
//   Manual LEFT on a board already packed left with no pairs -> MERGE->INPUT; board, score and move_count unchanged; no spawn.
//   Auto mode, ai_dir held 0 for SEARCH_TIMEOUT=100 cycles -> DOWN applied at cycle 100 (if legal).
//     Next test: ai_dir=3 on cycle 5 -> LEFT captured.
//   Board with one empty cell, LEFT merges 10+10 -> 11 -> CHECK -> END, won=1, game_over=1.
//     Full board with no equal neighbours after spawn -> END, won=0.
//   btn_restart during SEARCH and during END -> next cycle state=INPUT, board=INIT_BOARD, score=0.
//     Build with and without GAME_SCORE_EN: score stays 0 when disabled.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types and combinational helpers for the 2048 sequencer: state/dir codes,
// per-line slide/merge, direction-remapped board move and end-of-game predicates.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INPUT  = 3'd0,
    ST_MERGE  = 3'd1,
    ST_GEN    = 3'd2,
    ST_CHECK  = 3'd3,
    ST_END    = 3'd4,
    ST_SEARCH = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef struct packed {
    logic [15:0] cells;
    logic [16:0] gain;
  } line_t;

  typedef struct packed {
    logic [63:0] board;
    logic [19:0] gain;
  } move_t;

  // Board index for position pos (0 = wall side) of the given line number when moving in d.
  function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] line,
                                          input logic [1:0] pos);
    case (d)
      DIR_UP:    cell_idx = {pos, line};
      DIR_DOWN:  cell_idx = {~pos, line};
      DIR_RIGHT: cell_idx = {line, ~pos};
      default:   cell_idx = {line, pos};
    endcase
  endfunction

  function automatic line_t slide_line(input logic [15:0] in);
    logic [3:0] c [5];
    logic [1:0] n;
    logic [1:0] o;
    logic       skip;
    line_t      res;
    for (int i = 0; i < 5; i++) c[i] = 4'd0;
    res.cells = '0;
    res.gain  = '0;
    n    = 2'd0;
    o    = 2'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in[4*i +: 4] != 4'd0) begin
        c[n] = in[4*i +: 4];
        n    = n + 2'd1;
      end
    end
    // c[4] stays empty so the last slot never pairs; exponent 15 cannot grow.
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != 4'd0 && c[i] == c[i+1] && c[i] != 4'hF) begin
        res.cells[4*o +: 4] = c[i] + 4'd1;
        res.gain = res.gain + (17'd1 << (c[i] + 4'd1));
        o    = o + 2'd1;
        skip = 1'b1;
      end else if (c[i] != 4'd0) begin
        res.cells[4*o +: 4] = c[i];
        o = o + 2'd1;
      end
    end
    return res;
  endfunction

  function automatic move_t apply_move(input logic [63:0] b, input dir_t d);
    move_t       m;
    logic [15:0] ln;
    line_t       s;
    int          k;
    m.board = b;
    m.gain  = '0;
    for (int j = 0; j < 4; j++) begin
      for (int p = 0; p < 4; p++) begin
        k = int'(cell_idx(d, 2'(j), 2'(p)));
        ln[4*p +: 4] = b[4*k +: 4];
      end
      s = slide_line(ln);
      for (int p = 0; p < 4; p++) begin
        k = int'(cell_idx(d, 2'(j), 2'(p)));
        m.board[4*k +: 4] = s.cells[4*p +: 4];
      end
      m.gain = m.gain + 20'(s.gain);
    end
    return m;
  endfunction

  function automatic logic has_exp(input logic [63:0] b, input logic [3:0] e);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 16; i++) if (b[4*i +: 4] == e) f = 1'b1;
    return f;
  endfunction

  function automatic logic has_pair(input logic [63:0] b);
    logic p;
    p = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (b[16*r + 4*c +: 4] == b[16*r + 4*c + 4 +: 4]) p = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (b[16*r + 4*c +: 4] == b[16*r + 16 + 4*c +: 4]) p = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/game_ctrl_tile_spawner.sv
// Free-running spawn LFSR plus k-th-empty-cell selection; output is the board
// with one new tile placed (board unchanged when no cell is empty).
module tile_spawner
  import game_ctrl_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] board,
  output logic [63:0] spawned
);

  logic [15:0] lfsr;
  logic [4:0]  n_empty;
  logic [4:0]  k_sel;

  // x^16+x^14+x^13+x^11, right-shifting form.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  always_comb begin
    n_empty = 5'd0;
    for (int i = 0; i < 16; i++)
      if (board[4*i +: 4] == 4'd0) n_empty = n_empty + 5'd1;
  end

  assign k_sel = (n_empty == 5'd0) ? 5'd0 : 5'(lfsr[15:4] % {7'd0, n_empty});

  always_comb begin
    logic [4:0] seen;
    spawned = board;
    seen    = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (board[4*i +: 4] == 4'd0) begin
        if (seen == k_sel) spawned[4*i +: 4] = (lfsr[2:0] == 3'd0) ? 4'd2 : 4'd1;
        seen = seen + 5'd1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// 2048 turn sequencer: input/search, slide+merge, spawn, win/loss check.
// Define GAME_SCORE_EN to build the saturating score accumulator; otherwise score is 0.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter logic [63:0] INIT_BOARD     = 64'h0000_0000_0000_0011,
  parameter logic [3:0]  WIN_EXP        = 4'd11,
  parameter logic [31:0] SEARCH_TIMEOUT = 32'd20_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_restart,
  input  logic        auto_mode,
  input  logic [2:0]  ai_dir,
  output logic [2:0]  state,
  output logic [63:0] board,
  output logic        won,
  output logic        game_over,
  output logic [15:0] move_count,
  output logic [23:0] score
);

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d, btn_dir, fb_dir;
  logic [63:0] board_q, board_d, spawned;
  logic        won_q, won_d;
  logic [15:0] mc_q, mc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  btn_q, btn_now, btn_edge;
  logic        ai_ok, score_add, score_clr;
  move_t       mv_up, mv_down, mv_left, mv_right, mv_sel;

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  assign btn_now  = {btn_restart, btn_right, btn_left, btn_down, btn_up};
  assign btn_edge = btn_now & ~btn_q;
  assign ai_ok    = (ai_dir >= 3'd1) && (ai_dir <= 3'd4);

  assign mv_up    = apply_move(board_q, DIR_UP);
  assign mv_down  = apply_move(board_q, DIR_DOWN);
  assign mv_left  = apply_move(board_q, DIR_LEFT);
  assign mv_right = apply_move(board_q, DIR_RIGHT);

  tile_spawner #(.LFSR_SEED(LFSR_SEED)) u_spawner (
    .clk     (clk),
    .rst     (rst),
    .board   (board_q),
    .spawned (spawned)
  );

  always_comb begin
    btn_dir = DIR_NONE;
    if      (btn_edge[0]) btn_dir = DIR_UP;
    else if (btn_edge[1]) btn_dir = DIR_DOWN;
    else if (btn_edge[2]) btn_dir = DIR_LEFT;
    else if (btn_edge[3]) btn_dir = DIR_RIGHT;
  end

  // Timeout fallback: first direction that actually changes the board.
  always_comb begin
    fb_dir = DIR_DOWN;
    if      (mv_down.board  != board_q) fb_dir = DIR_DOWN;
    else if (mv_left.board  != board_q) fb_dir = DIR_LEFT;
    else if (mv_right.board != board_q) fb_dir = DIR_RIGHT;
    else if (mv_up.board    != board_q) fb_dir = DIR_UP;
  end

  always_comb begin
    case (dir_q)
      DIR_UP:    mv_sel = mv_up;
      DIR_DOWN:  mv_sel = mv_down;
      DIR_RIGHT: mv_sel = mv_right;
      default:   mv_sel = mv_left;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    board_d   = board_q;
    won_d     = won_q;
    mc_d      = mc_q;
    cnt_d     = cnt_q;
    score_add = 1'b0;
    score_clr = 1'b0;
    if (btn_edge[4]) begin
      state_d   = ST_INPUT;
      board_d   = INIT_BOARD;
      won_d     = 1'b0;
      mc_d      = 16'd0;
      cnt_d     = 32'd0;
      score_clr = 1'b1;
    end else begin
      case (state_q)
        ST_INPUT: begin
          cnt_d = 32'd0;
          if (auto_mode) begin
            state_d = ST_SEARCH;
          end else if (btn_dir != DIR_NONE) begin
            dir_d   = btn_dir;
            state_d = ST_MERGE;
          end
        end
        ST_SEARCH: begin
          if (ai_ok) begin
            dir_d   = dir_t'(ai_dir);
            state_d = ST_MERGE;
          end else if (cnt_q + 32'd1 >= SEARCH_TIMEOUT) begin
            dir_d   = fb_dir;
            state_d = ST_MERGE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_MERGE: begin
          if (mv_sel.board == board_q) begin
            state_d = ST_INPUT;
          end else begin
            board_d   = mv_sel.board;
            mc_d      = sat_inc16(mc_q);
            score_add = 1'b1;
            state_d   = ST_GEN;
          end
        end
        ST_GEN: begin
          board_d = spawned;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (has_exp(board_q, WIN_EXP)) begin
            won_d   = 1'b1;
            state_d = ST_END;
          end else if (!has_exp(board_q, 4'd0) && !has_pair(board_q)) begin
            state_d = ST_END;
          end else begin
            state_d = ST_INPUT;
          end
        end
        ST_END:  state_d = ST_END;
        default: state_d = ST_INPUT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INPUT;
      dir_q   <= DIR_LEFT;
      board_q <= INIT_BOARD;
      won_q   <= 1'b0;
      mc_q    <= 16'd0;
      cnt_q   <= 32'd0;
      btn_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      board_q <= board_d;
      won_q   <= won_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_now;
    end
  end

`ifdef GAME_SCORE_EN
  logic [23:0] score_q;

  function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [19:0] g);
    logic [24:0] s;
    s = {1'b0, a} + 25'(g);
    return s[24] ? 24'hFFFFFF : s[23:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           score_q <= 24'd0;
    else if (score_clr) score_q <= 24'd0;
    else if (score_add) score_q <= sat_add24(score_q, mv_sel.gain);
  end

  assign score = score_q;
`else
  logic unused_score;
  assign unused_score = ^{score_add, score_clr, mv_sel.gain};
  assign score        = 24'd0;
`endif

  assign state      = state_q;
  assign board      = board_q;
  assign won        = won_q;
  assign game_over  = (state_q == ST_END);
  assign move_count = mc_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: four instances, each loaded with a different start board.
module tb_game_ctrl;

`ifdef GAME_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  localparam logic [63:0] INITS [4] = '{
    64'h0000_0000_0000_0011,
    64'h0000_0000_0000_0211,
    64'h4321_9876_5432_01AA,
    64'h4365_6543_4365_5430
  };

  logic        clk, rst;
  logic [3:0]  up, dn, lf, rt, rs, am, won, go;
  logic [2:0]  ai [4];
  logic [2:0]  st [4];
  logic [63:0] bd [4];
  logic [15:0] mc [4];
  logic [23:0] sc [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    game_ctrl #(
      .INIT_BOARD     (INITS[g]),
      .WIN_EXP        (4'd11),
      .SEARCH_TIMEOUT (32'd100),
      .LFSR_SEED      (16'hACE1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (up[g]),
      .btn_down    (dn[g]),
      .btn_left    (lf[g]),
      .btn_right   (rt[g]),
      .btn_restart (rs[g]),
      .auto_mode   (am[g]),
      .ai_dir      (ai[g]),
      .state       (st[g]),
      .board       (bd[g]),
      .won         (won[g]),
      .game_over   (go[g]),
      .move_count  (mc[g]),
      .score       (sc[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference spawn LFSR: Fibonacci x^16+x^14+x^13+x^11, seed ACE1, steps every clock.
  logic [15:0] lfm;
  always @(posedge clk or negedge rst) begin
    if (!rst) lfm <= 16'hACE1;
    else      lfm <= (lfm >> 1) | (16'(((lfm >> 0) ^ (lfm >> 2) ^ (lfm >> 3) ^ (lfm >> 5)) & 16'd1) << 15);
  end

  typedef struct packed {
    logic [63:0] bd;
    logic [15:0] mc;
    logic [23:0] sc;
  } exp_t;

  exp_t sbq [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_state(input int g, input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (st[g] !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(st[g]), 64'(s));
  endtask

  function automatic logic [63:0] spawn_model(input logic [63:0] b, input logic [15:0] l);
    int n = 0;
    int seen = 0;
    int k;
    logic [63:0] r = b;
    for (int i = 0; i < 16; i++) if (b[4*i +: 4] == 4'd0) n++;
    if (n == 0) return b;
    k = int'(l[15:4]) % n;
    for (int i = 0; i < 16; i++) begin
      if (b[4*i +: 4] == 4'd0) begin
        if (seen == k) r[4*i +: 4] = (l[2:0] == 3'd0) ? 4'd2 : 4'd1;
        seen++;
      end
    end
    return r;
  endfunction

  // Called with the DUT in MERGE; checks the post-merge board against the
  // scoreboard, then the spawned board one cycle later in CHECK.
  task automatic finish_turn(input int g, input string tag, output logic [63:0] spawned);
    exp_t e;
    wait_state(g, 3'd2, 4, {tag, "_gen"});
    total++;
    assert (sbq.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    chk({tag, "_board"}, bd[g], e.bd);
    chk({tag, "_mc"}, 64'(mc[g]), 64'(e.mc));
    chk({tag, "_score"}, 64'(sc[g]), 64'(e.sc));
    spawned = spawn_model(e.bd, lfm);
    @(negedge clk);
    chk({tag, "_check"}, 64'(st[g]), 64'd3);
    chk({tag, "_spawn"}, bd[g], spawned);
  endtask

  initial begin
    logic [63:0] sp;
    up = '0; dn = '0; lf = '0; rt = '0; rs = '0; am = '0;
    for (int i = 0; i < 4; i++) ai[i] = 3'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_state", 64'(st[0]), 64'd0);
    chk("rst_board", bd[0], 64'h11);
    chk("rst_score", 64'(sc[0]), 64'd0);
    chk("rst_mc", 64'(mc[0]), 64'd0);
    chk("rst_won", 64'(won[0]), 64'd0);
    chk("rst_go", 64'(go[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Manual LEFT: [1,1,2,0] -> [2,2,0,0]
    chk("m_idle", 64'(st[1]), 64'd0);
    lf[1] = 1'b1;
    sbq.push_back('{bd: 64'h22, mc: 16'd1, sc: SCORE_ON ? 24'd4 : 24'd0});
    @(negedge clk);
    chk("m_merge", 64'(st[1]), 64'd1);
    lf[1] = 1'b0;
    finish_turn(1, "m_left", sp);
    @(negedge clk);
    chk("m_back", 64'(st[1]), 64'd0);
    chk("m_go", 64'(go[1]), 64'd0);

    // RIGHT changes nothing, then LEFT fills the board with no pairs left
    rt[3] = 1'b1;
    @(negedge clk);
    chk("n_merge", 64'(st[3]), 64'd1);
    rt[3] = 1'b0;
    @(negedge clk);
    chk("n_back", 64'(st[3]), 64'd0);
    chk("n_board", bd[3], INITS[3]);
    chk("n_mc", 64'(mc[3]), 64'd0);
    lf[3] = 1'b1;
    sbq.push_back('{bd: 64'h4365_6543_4365_0543, mc: 16'd1, sc: 24'd0});
    @(negedge clk);
    chk("l_merge", 64'(st[3]), 64'd1);
    lf[3] = 1'b0;
    finish_turn(3, "lose", sp);
    @(negedge clk);
    chk("lose_end", 64'(st[3]), 64'd4);
    chk("lose_won", 64'(won[3]), 64'd0);
    chk("lose_go", 64'(go[3]), 64'd1);
    up[3] = 1'b1;
    @(negedge clk);
    up[3] = 1'b0;
    @(negedge clk);
    chk("frozen_st", 64'(st[3]), 64'd4);
    chk("frozen_bd", bd[3], sp);

    // LEFT and RIGHT together: LEFT has priority; 10+10 -> 11 wins
    lf[2] = 1'b1;
    rt[2] = 1'b1;
    sbq.push_back('{bd: 64'h4321_9876_5432_001B, mc: 16'd1, sc: SCORE_ON ? 24'd2048 : 24'd0});
    @(negedge clk);
    chk("w_merge", 64'(st[2]), 64'd1);
    lf[2] = 1'b0;
    rt[2] = 1'b0;
    finish_turn(2, "win", sp);
    @(negedge clk);
    chk("win_end", 64'(st[2]), 64'd4);
    chk("win_won", 64'(won[2]), 64'd1);
    chk("win_go", 64'(go[2]), 64'd1);
    rs[2] = 1'b1;
    @(negedge clk);
    rs[2] = 1'b0;
    chk("rs_end_st", 64'(st[2]), 64'd0);
    chk("rs_end_bd", bd[2], INITS[2]);
    chk("rs_end_score", 64'(sc[2]), 64'd0);
    chk("rs_end_mc", 64'(mc[2]), 64'd0);
    chk("rs_end_won", 64'(won[2]), 64'd0);
    chk("rs_end_go", 64'(go[2]), 64'd0);

    // Auto mode: no AI answer -> DOWN fallback after the timeout
    am[0] = 1'b1;
    sbq.push_back('{bd: 64'h0011_0000_0000_0000, mc: 16'd1, sc: 24'd0});
    @(negedge clk);
    chk("a_search", 64'(st[0]), 64'd5);
    repeat (90) @(negedge clk);
    chk("a_still", 64'(st[0]), 64'd5);
    wait_state(0, 3'd1, 20, "a_timeout");
    finish_turn(0, "a_down", sp);
    @(negedge clk);
    chk("a_input", 64'(st[0]), 64'd0);
    @(negedge clk);
    chk("a_search2", 64'(st[0]), 64'd5);
    rs[0] = 1'b1;
    @(negedge clk);
    rs[0] = 1'b0;
    chk("rs_srch_st", 64'(st[0]), 64'd0);
    chk("rs_srch_bd", bd[0], 64'h11);
    chk("rs_srch_mc", 64'(mc[0]), 64'd0);
    chk("rs_srch_score", 64'(sc[0]), 64'd0);
    @(negedge clk);
    chk("a_search3", 64'(st[0]), 64'd5);
    repeat (3) @(negedge clk);
    chk("a_wait", 64'(st[0]), 64'd5);
    ai[0] = 3'd3;
    sbq.push_back('{bd: 64'h2, mc: 16'd1, sc: SCORE_ON ? 24'd4 : 24'd0});
    @(negedge clk);
    chk("a_capture", 64'(st[0]), 64'd1);
    ai[0] = 3'd0;
    am[0] = 1'b0;
    finish_turn(0, "a_left", sp);
    @(negedge clk);
    chk("a_done", 64'(st[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
